// File: rtl/hazard_unit_pkg.sv
// Shared opcode encodings and the attribute/shadow bundles
// used by the MIPS-lite hazard unit.
package hazard_unit_pkg;

   localparam logic [5:0] OP_R_TYPE = 6'b000000;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_JAL    = 6'b000011;

   typedef struct packed {
      logic       uses_rs;
      logic       uses_rt;
      logic [4:0] dst;
      logic       load;
   } src_attr_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       load;
   } shadow_t;

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage fields and branch outcome in, issue/write/flush
// controls and bubble counter out.
interface hazard_unit_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       id_op;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic [4:0]       id_rd;
   logic             branch_taken;
   logic             stall;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output id_op, id_rs, id_rt, id_rd,
      output branch_taken,
      input  stall, pc_write, ifid_write,
      input  ifid_flush, bubble_cnt
   );

   modport slave (
      input  id_op, id_rs, id_rt, id_rd,
      input  branch_taken,
      output stall, pc_write, ifid_write,
      output ifid_flush, bubble_cnt
   );
endinterface

// File: rtl/hazard_src_decode.sv
// Maps the ID opcode to source usage, destination and
// load flag; register 0 destinations come out as zero.
module hazard_src_decode
   import hazard_unit_pkg::*;
#(
   parameter int JAL_REG = 31
) (
   input  logic [5:0] op,
   input  logic [4:0] rt,
   input  logic [4:0] rd,
   output src_attr_t  attr
);

   localparam logic [4:0] JAL_DST = 5'(JAL_REG);

   always_comb begin
      attr = '0;
      unique case (1'b1)
         (op == OP_R_TYPE): begin
            attr.uses_rs = 1'b1;
            attr.uses_rt = 1'b1;
            attr.dst     = rd;
         end
         (op == OP_ORI): begin
            attr.uses_rs = 1'b1;
            attr.dst     = rt;
         end
         (op == OP_LW): begin
            attr.uses_rs = 1'b1;
            attr.dst     = rt;
            attr.load    = 1'b1;
         end
         (op == OP_SW),
         (op == OP_BEQ): begin
            attr.uses_rs = 1'b1;
            attr.uses_rt = 1'b1;
         end
         (op == OP_JAL): begin
            attr.dst = JAL_DST;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-operand hazard detection with EX and MEM
// destination shadows and a saturating bubble counter.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int JAL_REG = 31
) (
   input  logic          clk,
   input  logic          rst,
   hazard_unit_if.slave  bus
);

   src_attr_t        attr;
   shadow_t          ex_q;
   shadow_t          mem_q;
   logic [CNT_W-1:0] cnt_q;

   logic is_beq;
   logic is_jal;
   logic ex_hit_src;
   logic ex_hit_br;
   logic mem_hit_br;
   logic hz;

   logic stall;
   logic pc_write;
   logic ifid_write;
   logic ifid_flush;

   hazard_src_decode #(
      .JAL_REG (JAL_REG)
   ) u_dec (
      .op   (bus.id_op),
      .rt   (bus.id_rt),
      .rd   (bus.id_rd),
      .attr (attr)
   );

   assign is_beq = (bus.id_op == OP_BEQ);
   assign is_jal = (bus.id_op == OP_JAL);

   assign ex_hit_src = ex_q.valid &
      ((attr.uses_rs & (ex_q.dst == bus.id_rs)) |
       (attr.uses_rt & (ex_q.dst == bus.id_rt)));

   assign ex_hit_br = ex_q.valid &
      ((ex_q.dst == bus.id_rs) |
       (ex_q.dst == bus.id_rt));

   assign mem_hit_br = mem_q.valid &
      ((mem_q.dst == bus.id_rs) |
       (mem_q.dst == bus.id_rt));

   assign hz = (ex_q.load & ex_hit_src) |
               (is_beq & ex_hit_br) |
               (is_beq & mem_q.load & mem_hit_br);

   // A taken branch makes the ID instruction wrong-path, so it
   // outranks any hazard it might appear to have.
   always_comb begin
      stall      = 1'b1;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      priority case (1'b1)
         bus.branch_taken: begin
            stall      = 1'b0;
            ifid_flush = 1'b1;
         end
         hz: begin
            stall      = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         is_jal: begin
            ifid_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
      end else begin
         mem_q <= ex_q;
         if (stall) begin
            ex_q.valid <= (attr.dst != 5'd0);
            ex_q.dst   <= attr.dst;
            ex_q.load  <= attr.load;
         end else begin
            ex_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!stall && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall      = stall;
   assign bus.pc_write   = pc_write;
   assign bus.ifid_write = ifid_write;
   assign bus.ifid_flush = ifid_flush;
   assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: directed corner sequences then random
// instruction streams against an in-flight-list reference model.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hazard_unit_if #(.CNT_W(16)) bus16 ();
   hazard_unit_if #(.CNT_W(4))  bus4 ();

   hazard_unit #(.CNT_W(16), .JAL_REG(31)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16.slave)
   );

   hazard_unit #(.CNT_W(4), .JAL_REG(31)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   typedef struct {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       bt;
      logic       rst;
   } stim_t;

   typedef struct {
      logic        stall;
      logic        pcw;
      logic        ifw;
      logic        flush;
      logic [15:0] c16;
      logic [3:0]  c4;
      logic        stall4;
   } exp_t;

   typedef struct {
      bit       has_dst;
      bit [4:0] dst;
      bit       load;
   } flight_t;

   exp_t    sb[$];
   stim_t   dir[$];
   flight_t inflight[2];
   int      m_c16;
   int      m_c4;
   int      errors = 0;
   int      checks = 0;
   bit      done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) inflight[i] = '{0, 0, 0};
      m_c16 = 0;
      m_c4  = 0;
   endtask

   // One cycle: drive inputs, predict outputs, advance model.
   task automatic drive(input stim_t s, output bit advanced);
      bit urs, urt, ld, beq, haz, st, pcw, ifw, fl;
      bit [4:0] dst;
      exp_t e;
      rst = s.rst;
      bus16.id_op = s.op; bus4.id_op = s.op;
      bus16.id_rs = s.rs; bus4.id_rs = s.rs;
      bus16.id_rt = s.rt; bus4.id_rt = s.rt;
      bus16.id_rd = s.rd; bus4.id_rd = s.rd;
      bus16.branch_taken = s.bt;
      bus4.branch_taken  = s.bt;
      if (s.rst) model_reset();
      urs = 0; urt = 0; dst = 0; ld = 0;
      case (s.op)
         OP_R_TYPE: begin urs = 1; urt = 1; dst = s.rd; end
         OP_ORI:    begin urs = 1; dst = s.rt; end
         OP_LW:     begin urs = 1; dst = s.rt; ld = 1; end
         OP_SW:     begin urs = 1; urt = 1; end
         OP_BEQ:    begin urs = 1; urt = 1; end
         OP_JAL:    dst = 5'd31;
         default:   ;
      endcase
      beq = (s.op == OP_BEQ);
      haz = 0;
      if (inflight[0].has_dst && inflight[0].load &&
          ((urs && s.rs == inflight[0].dst) ||
           (urt && s.rt == inflight[0].dst)))
         haz = 1;
      if (beq && inflight[0].has_dst &&
          (s.rs == inflight[0].dst || s.rt == inflight[0].dst))
         haz = 1;
      if (beq && inflight[1].has_dst && inflight[1].load &&
          (s.rs == inflight[1].dst || s.rt == inflight[1].dst))
         haz = 1;
      if (s.bt) begin
         st = 0; pcw = 1; ifw = 1; fl = 1;
      end else if (haz) begin
         st = 0; pcw = 0; ifw = 0; fl = 0;
      end else begin
         st = 1; pcw = 1; ifw = 1; fl = (s.op == OP_JAL);
      end
      e.stall = st; e.pcw = pcw; e.ifw = ifw; e.flush = fl;
      e.c16 = 16'(m_c16); e.c4 = 4'(m_c4); e.stall4 = st;
      sb.push_back(e);
      if (!s.rst) begin
         inflight[1] = inflight[0];
         if (st) inflight[0] = '{dst != 0, dst, ld};
         else    inflight[0] = '{0, 0, 0};
         if (!st) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15) m_c4++;
         end
      end
      advanced = ifw || s.rst;
   endtask

   task automatic add(input logic [5:0] op, input int rs, input int rt,
                      input int rd, input bit bt, input bit r);
      stim_t s;
      s.op = op; s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd);
      s.bt = bt; s.rst = r;
      dir.push_back(s);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      logic [5:0] ops[7];
      ops[0] = OP_R_TYPE; ops[1] = OP_ORI; ops[2] = OP_LW;
      ops[3] = OP_SW; ops[4] = OP_BEQ; ops[5] = OP_JAL;
      ops[6] = 6'h3f;
      s.op = ops[$urandom_range(0, 6)];
      s.rs = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      s.bt = 0;
      s.rst = 0;
      return s;
   endfunction

   // Monitor: compare whatever the scoreboard expects this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall", 32'(bus16.stall), 32'(e.stall));
            chk("pc_write", 32'(bus16.pc_write), 32'(e.pcw));
            chk("ifid_write", 32'(bus16.ifid_write), 32'(e.ifw));
            chk("ifid_flush", 32'(bus16.ifid_flush), 32'(e.flush));
            chk("bubble_cnt16", 32'(bus16.bubble_cnt), 32'(e.c16));
            chk("bubble_cnt4", 32'(bus4.bubble_cnt), 32'(e.c4));
            chk("stall_w4", 32'(bus4.stall), 32'(e.stall4));
         end
      end
   end

   initial begin
      stim_t cur;
      bit adv;
      model_reset();
      add(OP_R_TYPE, 0, 0, 0, 0, 1);
      add(OP_R_TYPE, 0, 0, 0, 0, 1);
      add(OP_LW, 1, 2, 0, 0, 0);
      add(OP_R_TYPE, 2, 5, 6, 0, 0);
      add(OP_R_TYPE, 2, 5, 6, 0, 0);
      add(OP_R_TYPE, 0, 0, 0, 0, 0);
      add(OP_LW, 1, 3, 0, 0, 0);
      add(OP_BEQ, 3, 1, 0, 0, 0);
      add(OP_BEQ, 3, 1, 0, 0, 0);
      add(OP_BEQ, 3, 1, 0, 0, 0);
      add(OP_R_TYPE, 0, 0, 0, 0, 0);
      add(OP_ORI, 1, 4, 0, 0, 0);
      add(OP_BEQ, 1, 4, 0, 0, 0);
      add(OP_BEQ, 1, 4, 0, 0, 0);
      add(OP_ORI, 1, 0, 0, 0, 0);
      add(OP_BEQ, 0, 0, 0, 0, 0);
      add(OP_R_TYPE, 0, 0, 0, 0, 0);
      add(OP_LW, 1, 5, 0, 0, 0);
      add(OP_R_TYPE, 5, 0, 6, 1, 0);
      add(OP_R_TYPE, 0, 0, 0, 0, 0);
      add(OP_JAL, 0, 0, 0, 0, 0);
      add(OP_R_TYPE, 31, 1, 2, 0, 0);
      add(OP_R_TYPE, 0, 0, 0, 0, 0);
      add(OP_LW, 1, 7, 0, 0, 0);
      add(OP_BEQ, 7, 0, 0, 0, 0);
      add(OP_BEQ, 7, 0, 0, 0, 1);
      add(OP_BEQ, 7, 0, 0, 0, 0);
      add(OP_R_TYPE, 0, 0, 0, 0, 0);
      foreach (dir[i]) begin
         @(posedge clk);
         #1;
         drive(dir[i], adv);
      end
      // ID is held whenever IF/ID is not written, as in the pipeline.
      cur = rand_stim();
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         cur.bt  = ($urandom_range(0, 7) == 0);
         cur.rst = ($urandom_range(0, 199) == 0);
         drive(cur, adv);
         if (adv) cur = rand_stim();
      end
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d want 0 pending", sb.size());
      end
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection block for the MIPS-lite 5-stage pipeline; it produces the `stall` issue-enable that the decode controller consumes, plus PC/IF-ID write enables and the IF/ID flush. It watches the instruction in ID (op, rs, rt, rd) and the EX-stage branch outcome. It keeps its own shadow of the destination registers in flight in EX and MEM, so it detects load-use and branch-operand hazards without reading the datapath pipeline registers. It also keeps a saturating count of bubble cycles for performance debug.

## Interface
Parameters:
- `CNT_W`, 16: width of the bubble counter.
- `JAL_REG`, 31: register index written by JAL.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `id_op`  input  6  opcode of the instruction in ID; encodings come from `head.v`.
- `id_rs`  input  5  rs field in ID.
- `id_rt`  input  5  rt field in ID.
- `id_rd`  input  5  rd field in ID.
- `branch_taken`  input  1  one-cycle pulse from EX when a BEQ there resolves taken.
- `stall`  output  1  issue enable to the controller. 1 issues the ID instruction; 0 forces an all-zero control word (bubble). The polarity matches the controller's `stall` port.
- `pc_write`  output  1  PC register write enable.
- `ifid_write`  output  1  IF/ID register write enable.
- `ifid_flush`  output  1  clears IF/ID to a NOP on the next edge.
- `bubble_cnt`  output  `CNT_W`  saturating count of cycles with `stall`=0.

## Operation
Per-opcode attributes for the ID instruction:
- R-type: source rs and rt, destination rd, not a load.
- ORI: source rs, destination rt.
- LW: source rs, destination rt, load.
- SW: source rs and rt, no destination.
- BEQ: source rs and rt, no destination.
- JAL: no sources, destination `JAL_REG`.
- Unknown op: no sources, no destination.
- A destination of register 0 is treated as no destination.

Shadow stages:
- Each of EX and MEM holds {valid, dst[4:0], load}.
- On every edge, MEM takes the EX contents.
- EX takes the ID attributes when `stall`=1; otherwise EX becomes invalid.

Hazard detection (combinational, current cycle). `hz` is asserted when any of these holds:
- (a) EX is a valid load and its dst equals any ID source.
- (b) ID is BEQ and EX is valid with dst equal to rs or rt.
- (c) ID is BEQ and MEM is a valid load with dst equal to rs or rt.

Output equations, in priority order:
- `branch_taken`=1: `stall`=0, `ifid_flush`=1, `pc_write`=1, `ifid_write`=1. The hazard is ignored because the ID instruction is wrong-path.
- else `hz`=1: `stall`=0, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0.
- else if ID is JAL: `stall`=1, `ifid_flush`=1, `pc_write`=1, `ifid_write`=1.
- else: `stall`=1, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0.

Counter:
- `bubble_cnt` increments on each edge where `stall`=0.
- It holds at all-ones once saturated.

## Timing
- Reset (asynchronous, effective immediately):
  - EX and MEM invalid.
  - `bubble_cnt`=0.
  - With `branch_taken`=0 and ID op 000000 with rs=rt=0: `stall`=1, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0.
- All four control outputs are combinational from the registered shadow state and the current inputs, with zero cycles of latency.
- Load-use stall (a) lasts exactly 1 cycle, because the bubble enters EX and the load moves to MEM.
- LW immediately followed by a dependent BEQ stalls 2 cycles: (a)+(b) in the first cycle, then (c) in the second.
- ALU result followed by a dependent BEQ stalls 1 cycle.
- `branch_taken` coincident with a hazard: the flush wins and the shadow EX becomes invalid.
- Reset asserted mid-stall clears the shadow state; the first cycle after deassertion issues normally.

## Structure
- Opcode constants (`OP_R_TYPE`, `OP_ORI`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_JAL`) are shared from `head.v`, not redefined here. Add `JAL_REG` there if other blocks need it.
- One natural sub-module: `hazard_src_decode`, a combinational map from op/rs/rt/rd to {uses_rs, uses_rt, dst, load}.
- The top level holds the shadow stages, the hazard compare and the counter.

## Test plan
- LW $2 issued, next ID is R-type with rs=2 -> `stall`=0, `pc_write`=0, `ifid_write`=0 for exactly 1 cycle, then `stall`=1; `bubble_cnt`=1.
- LW $3, then BEQ with rs=3 -> 2 consecutive cycles of `stall`=0, then issue; `bubble_cnt`=2.
- ORI $4, then BEQ with rt=4 -> 1 bubble. ORI $0, then BEQ with rs=0 -> no bubble.
- ID holds a load-use hazard and `branch_taken`=1 in the same cycle -> `stall`=0, `ifid_flush`=1, `pc_write`=1; the next cycle has no hazard and the counter increments by 1.
- JAL in ID with no hazard -> `stall`=1, `ifid_flush`=1. A following R-type with rs=31 sees EX dst=31, which is not a load, so no stall.
- With `CNT_W`=4, force 20 hazard cycles -> `bubble_cnt` saturates at 15. Assert `rst` during a stall -> all outputs return to their reset values in the same cycle.
